regfile_multiport: RTL
======================

# regfile_multiport

Parametrised general-purpose register file for the MIPS datapath, generalising the fixed 32x32, two-read-port file. It has a configurable number of read ports, registered reads and an optional write-to-read bypass. A sequential clear engine zeroes storage one entry per cycle after reset or on request, so the storage array has no asynchronous reset. It sits between the decode stage (read addresses) and the writeback stage (write port).

## Interface
Parameters:
- DATA_W, 32, width of each register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port p data at bits [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  port p data valid, one-cycle pulse
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  request a full clear sweep
- busy  out  1  clear sweep in progress; reads and writes are ignored

## Operation
- State machine: IDLE, CLEAR. The clear counter clr_idx is ADDR_W bits wide.
- Reset (rst=1), asynchronous: state=CLEAR, clr_idx=0, busy=1, rd_data=0, rd_valid=0. Storage is not reset directly.
- CLEAR state:
  - Each edge writes 0 to mem[clr_idx] and increments clr_idx.
  - At clr_idx=DEPTH-1 the machine writes that entry and goes to IDLE, with no wrap-around.
  - rd_en, wr_en and clr_req are ignored; rd_valid=0; rd_data holds its value.
- IDLE state:
  - clr_req=1 moves to CLEAR with clr_idx=0.
  - A wr_en in the same cycle as clr_req is dropped, because clr_req has priority.
- Write: when IDLE, wr_en=1 and no clr_req, mem[wr_addr] is updated at the edge.
  - If ZERO_REG=1 and wr_addr=0, the write is discarded.
- Read port p: when IDLE and rd_en[p]=1, rd_data[p] loads mem[rd_addr[p]] at the edge and rd_valid[p]=1 for one cycle. Otherwise rd_data[p] holds and rd_valid[p]=0.
  - If ZERO_REG=1 and rd_addr[p]=0, rd_data[p] loads 0 regardless of storage or bypass.
- Multiple ports may read the same address in the same cycle; every one of them returns identical data.

## Timing
- Read latency: 1 cycle, from the address sampled at edge E to data and rd_valid visible after E.
- Write is visible to reads sampled at edge E+1 or later. Same-edge behaviour is set by the Configuration macro.
- After rst deasserts, busy stays high for exactly DEPTH rising edges (32 by default) and drops after edge DEPTH.
- clr_req sampled at edge E:
  - busy=1 after E.
  - Entry i is zeroed at edge E+1+i.
  - busy=0 after edge E+DEPTH.
- rst asserted mid-sweep restarts the sweep from clr_idx=0.
- clr_req held high continuously re-arms a sweep on the first IDLE edge after each sweep ends.

## Configuration
- REGFILE_BYPASS_EN defined: when a write and a read are accepted at the same edge with rd_addr[p]==wr_addr, rd_data[p] loads wr_data (write-first). Address 0 is excluded when ZERO_REG=1.
- REGFILE_BYPASS_EN undefined: the same-edge read returns the old mem contents (read-first), and the new value appears from the next read.

## Test plan
- Reset, then poll busy -> busy=1 for 32 edges after rst falls, then 0; a read of any address (e.g. 17) returns 0x00000000 with rd_valid=1 one cycle later.
- Write 0xDEADBEEF to r5, then read r5 on port 0 and port 1 at the next edge -> both return 0xDEADBEEF after 1 cycle, each with a single-cycle rd_valid.
- Same-edge write r9=0x12345678 and read r9 (r9 previously 0x0) -> 0x12345678 with REGFILE_BYPASS_EN, 0x00000000 without.
- Write 0xFFFFFFFF to r0, then read r0 -> 0x00000000 (ZERO_REG=1).
- Fill r1..r31 with nonzero values, pulse clr_req with a concurrent write r3=0xAA -> write dropped; busy high 32 cycles; reads during busy give rd_valid=0; every register reads 0 afterwards.
- Assert rst at sweep cycle 10 of a clr_req sweep -> rd_data=0 and rd_valid=0 immediately; busy stays high for 32 edges after rst release.

Source files
------------

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - register file read/write/clear bus between datapath and regfile_multiport
interface regfile_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     clr_req;
    logic                     busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-read-port register file with sequential clear; REGFILE_BYPASS_EN selects write-first same-edge reads
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    regfile_multiport_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        clr_idx_q, clr_idx_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     wr_acc;

    // Storage has a single write port shared by the clear sweep and the writeback port.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        wr_acc    = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            default: begin
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0)) begin
                    wr_acc = 1'b1;
                    mem_we = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        if (state_q == IDLE) begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (bus.rd_en[p]) begin
                    rd_valid_d[p] = 1'b1;
                    if (ZERO_REG != 0 && bus.rd_addr[p*ADDR_W +: ADDR_W] == '0) begin
                        rd_data_d[p*DATA_W +: DATA_W] = '0;
                    end else if (BYPASS && wr_acc && bus.rd_addr[p*ADDR_W +: ADDR_W] == bus.wr_addr) begin
                        rd_data_d[p*DATA_W +: DATA_W] = bus.wr_data;
                    end else begin
                        rd_data_d[p*DATA_W +: DATA_W] = mem[bus.rd_addr[p*ADDR_W +: ADDR_W]];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_idx_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state_q == CLEAR);
endmodule
